// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the default operand width.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } mdState_t;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH);

  function automatic logic isSignedOp(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage port bundle of the multiply/divide unit. The master is the
// execute stage / hazard unit; the slave is muldiv_unit.
interface muldiv_if #(parameter int WIDTH = 32);

  // Handshake: start is taken only while busy=0; done pulses for one cycle with
  // the new hi/lo already visible, and a new start may be issued in that cycle.
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             mf_req;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             stall_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel, hi_we, lo_we, wdata, mf_req,
    input  busy, done, div_by_zero, stall_req, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, hi_we, lo_we, wdata, mf_req,
    output busy, done, div_by_zero, stall_req, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for multiply, or
// restoring trial-subtract for divide, on a 2*WIDTH accumulator.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               isDiv,
  output logic [2*WIDTH-1:0] accNext
);

  logic [WIDTH:0] addSum;
  logic [WIDTH:0] shiftRem;
  logic [WIDTH:0] trialDiff;

  always_comb begin
    addSum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // Remainder shifted left, pulling in the next dividend bit from the low half.
    shiftRem  = acc[2*WIDTH-1:WIDTH-1];
    trialDiff = shiftRem - {1'b0, opnd};
    if (isDiv) begin
      if (!trialDiff[WIDTH]) accNext = {trialDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                   accNext = {shiftRem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      accNext = {addSum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers,
// start/busy/done handshake and a stall request for MFHI/MFLO.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus,
  output mdState_t dbgState
);

  localparam int CNT_W = $clog2(WIDTH);

  mdState_t           state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] accNext;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;
  logic               isDiv;
  logic               negQ;
  logic               negR;
  logic               bZero;
  logic               doneReg;
  logic               dbz;
  logic               dbzSaved;

  logic               busy;
  logic               accept;
  logic               signedOp;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   resHi;
  logic [WIDTH-1:0]   resLo;

  assign busy     = (state != S_IDLE);
  assign accept   = (state == S_IDLE) && bus.start && !bus.cancel;
  assign signedOp = isSignedOp(bus.op);

  // The most-negative operand keeps its bit pattern, which is its correct unsigned magnitude.
  always_comb begin
    magA = (signedOp && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    magB = (signedOp && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  muldiv_step #(.WIDTH(WIDTH)) uStep (
    .acc     (acc),
    .opnd    (opnd),
    .isDiv   (isDiv),
    .accNext (accNext)
  );

  always_comb begin
    prodFix = negQ ? -acc : acc;
    resHi   = prodFix[2*WIDTH-1:WIDTH];
    resLo   = prodFix[WIDTH-1:0];
    if (isDiv) begin
      if (bZero) begin
        resHi = dividend;
        resLo = '1;
      end else begin
        resLo = negQ ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        resHi = negR ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      dividend <= '0;
      hiReg    <= '0;
      loReg    <= '0;
      isDiv    <= 1'b0;
      negQ     <= 1'b0;
      negR     <= 1'b0;
      bZero    <= 1'b0;
      doneReg  <= 1'b0;
      dbz      <= 1'b0;
      dbzSaved <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      if (!busy) begin
        if (bus.hi_we) hiReg <= bus.wdata;
        if (bus.lo_we) loReg <= bus.wdata;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= S_RUN;
            cnt      <= CNT_W'(WIDTH - 1);
            isDiv    <= bus.op[1];
            negQ     <= signedOp && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            negR     <= signedOp && bus.a[WIDTH-1];
            bZero    <= (bus.b == '0);
            dividend <= bus.a;
            opnd     <= bus.op[1] ? magB : magA;
            acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? magA : magB)};
            // A cancelled operation must leave the flag as it was before this start.
            dbzSaved <= dbz;
            dbz      <= 1'b0;
          end
        end
        S_RUN: begin
          if (bus.cancel) begin
            state <= S_IDLE;
            dbz   <= dbzSaved;
          end else begin
            acc <= accNext;
            if (cnt == '0) state <= S_FIX;
            else           cnt   <= cnt - 1'b1;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (bus.cancel) begin
            dbz <= dbzSaved;
          end else begin
            hiReg   <= resHi;
            loReg   <= resLo;
            doneReg <= 1'b1;
            dbz     <= isDiv && bZero;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = doneReg;
  assign bus.div_by_zero = dbz;
  assign bus.stall_req   = bus.mf_req & busy;
  assign bus.hi          = hiReg;
  assign bus.lo          = loReg;
  assign dbgState        = state;

endmodule
